// File: rtl/flash_read_pkg.sv
// Shared state encoding and SPI flash opcodes for flash_read_sequencer.
package flash_read_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_PUSH,
        ST_FINISH
    } state_t;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] DUMMY_BYTE    = 8'h00;

endpackage

// File: rtl/flash_read_sequencer.sv
// Sequences one SPI flash READ: command, address, optional dummy, then data bytes into the read FIFO.
// Optional FAST_READ_EN selects opcode 0x0B plus one discarded dummy byte after the address.
module flash_read_sequencer
    import flash_read_pkg::*;
#(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned LEN_W  = 9,
    parameter int unsigned DATA_W = 8
) (
    input  logic              system_clk,
    input  logic              system_reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  byte_len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              spi_cs_n,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_tx_data,
    input  logic              xfer_done,
    input  logic [DATA_W-1:0] xfer_rx_data,
    output logic              fifo_write_req,
    output logic [DATA_W-1:0] fifo_dataIn,
    output logic              fifo_enable,
    input  logic              fifo_full
);

    localparam int unsigned ADDR_BYTES = ADDR_W / 8;
    localparam int unsigned CNT_W      = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_ADDR_IDX = CNT_W'(ADDR_BYTES - 1);

`ifdef FAST_READ_EN
    localparam logic [7:0] CMD_OPCODE    = CMD_FAST_READ;
    localparam state_t     ST_AFTER_ADDR = ST_DUMMY;
`else
    localparam logic [7:0] CMD_OPCODE    = CMD_READ;
    localparam state_t     ST_AFTER_ADDR = ST_DATA;
`endif

    state_t              r_state, w_state_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic                r_cs_n, w_cs_n_nxt;
    logic                r_req, w_req_nxt;
    logic [DATA_W-1:0]   r_tx, w_tx_nxt;
    logic                r_wr, w_wr_nxt;
    logic [DATA_W-1:0]   r_din, w_din_nxt;
    logic                r_fifo_en;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [CNT_W-1:0]    r_addr_idx, w_addr_idx_nxt;
    logic [LEN_W-1:0]    r_remaining, w_remaining_nxt;
    logic                w_ack;

    // A completion only counts while our request is outstanding.
    assign w_ack = r_req & xfer_done;

    always_ff @(posedge system_clk or posedge system_reset) begin
        if (system_reset) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_req       <= 1'b0;
            r_tx        <= '0;
            r_wr        <= 1'b0;
            r_din       <= '0;
            r_fifo_en   <= 1'b1;
            r_addr      <= '0;
            r_addr_idx  <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_req       <= w_req_nxt;
            r_tx        <= w_tx_nxt;
            r_wr        <= w_wr_nxt;
            r_din       <= w_din_nxt;
            r_fifo_en   <= 1'b1;
            r_addr      <= w_addr_nxt;
            r_addr_idx  <= w_addr_idx_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_cs_n_nxt      = r_cs_n;
        w_req_nxt       = r_req;
        w_tx_nxt        = r_tx;
        w_wr_nxt        = 1'b0;
        w_din_nxt       = r_din;
        w_addr_nxt      = r_addr;
        w_addr_idx_nxt  = r_addr_idx;
        w_remaining_nxt = r_remaining;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (byte_len != '0) begin
                        w_addr_nxt      = start_addr;
                        w_remaining_nxt = byte_len;
                        w_addr_idx_nxt  = '0;
                        w_busy_nxt      = 1'b1;
                        w_cs_n_nxt      = 1'b0;
                        w_tx_nxt        = DATA_W'(CMD_OPCODE);
                        w_req_nxt       = 1'b1;
                        w_state_nxt     = ST_CMD;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            ST_CMD: begin
                if (w_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_ADDR;
                end
            end
            // Address goes out MSB byte first from a left-shifting copy.
            ST_ADDR: begin
                if (w_ack) begin
                    w_req_nxt  = 1'b0;
                    w_addr_nxt = r_addr << 8;
                    if (r_addr_idx == LAST_ADDR_IDX) begin
                        w_state_nxt = ST_AFTER_ADDR;
                    end else begin
                        w_addr_idx_nxt = r_addr_idx + CNT_W'(1);
                    end
                end else if (!r_req) begin
                    w_tx_nxt  = DATA_W'(r_addr[ADDR_W-1 -: 8]);
                    w_req_nxt = 1'b1;
                end
            end
            ST_DUMMY: begin
                if (w_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_DATA;
                end else if (!r_req) begin
                    w_tx_nxt  = DATA_W'(DUMMY_BYTE);
                    w_req_nxt = 1'b1;
                end
            end
            // New data bytes are only requested when the FIFO has room.
            ST_DATA: begin
                if (w_ack) begin
                    w_req_nxt   = 1'b0;
                    w_din_nxt   = xfer_rx_data;
                    w_wr_nxt    = 1'b1;
                    w_state_nxt = ST_PUSH;
                end else if (!r_req && !fifo_full) begin
                    w_tx_nxt  = DATA_W'(DUMMY_BYTE);
                    w_req_nxt = 1'b1;
                end
            end
            ST_PUSH: begin
                w_remaining_nxt = r_remaining - LEN_W'(1);
                w_state_nxt     = (r_remaining == LEN_W'(1)) ? ST_FINISH : ST_DATA;
            end
            ST_FINISH: begin
                w_cs_n_nxt  = 1'b1;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort wins over any completion arriving in the same cycle.
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
            w_cs_n_nxt  = 1'b1;
            w_wr_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign spi_cs_n       = r_cs_n;
    assign xfer_req       = r_req;
    assign xfer_tx_data   = r_tx;
    assign fifo_write_req = r_wr;
    assign fifo_dataIn    = r_din;
    assign fifo_enable    = r_fifo_en;

endmodule

// File: tb/tb_flash_read_sequencer.sv
// Self-checking bench for flash_read_sequencer: SPI byte-engine model plus tx/FIFO scoreboards.
module tb_flash_read_sequencer;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned LEN_W  = 9;
    localparam int unsigned DATA_W = 8;
`ifdef FAST_READ_EN
    localparam int HDR = 5;
    localparam logic [7:0] EXP_CMD = 8'h0B;
`else
    localparam int HDR = 4;
    localparam logic [7:0] EXP_CMD = 8'h03;
`endif

    logic              system_clk = 1'b0;
    logic              system_reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [LEN_W-1:0]  byte_len = '0;
    logic              abort = 1'b0;
    logic              busy;
    logic              done;
    logic              spi_cs_n;
    logic              xfer_req;
    logic [DATA_W-1:0] xfer_tx_data;
    logic              xfer_done = 1'b0;
    logic [DATA_W-1:0] xfer_rx_data = '0;
    logic              fifo_write_req;
    logic [DATA_W-1:0] fifo_dataIn;
    logic              fifo_enable;
    logic              fifo_full = 1'b0;

    always #5 system_clk = ~system_clk;

    flash_read_sequencer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .system_clk     (system_clk),
        .system_reset   (system_reset),
        .start          (start),
        .start_addr     (start_addr),
        .byte_len       (byte_len),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .spi_cs_n       (spi_cs_n),
        .xfer_req       (xfer_req),
        .xfer_tx_data   (xfer_tx_data),
        .xfer_done      (xfer_done),
        .xfer_rx_data   (xfer_rx_data),
        .fifo_write_req (fifo_write_req),
        .fifo_dataIn    (fifo_dataIn),
        .fifo_enable    (fifo_enable),
        .fifo_full      (fifo_full)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_fifo[$];
    logic [7:0] eng_exp, mon_exp;
    int done_cnt = 0, wr_cnt = 0, req_cycles = 0, cs_low_cycles = 0, cs_hi_busy = 0;
    int eng_cnt = 0, bi = 0, wcnt = 0, lat = 1, fixed_lat = 0;

    // SPI byte engine: answers each request after 1-3 cycles; rx is 0xA0+n for data bytes.
    always @(negedge system_clk) begin
        if (spi_cs_n) bi = 0;
        if (system_reset) begin
            xfer_done = 1'b0;
            wcnt = 0;
        end else if (xfer_done) begin
            xfer_done = 1'b0;
        end else if (xfer_req) begin
            if (wcnt == 0) lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(3, 1));
            wcnt++;
            if (wcnt >= lat) begin
                eng_cnt++;
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte unexpected transfer got %h", xfer_tx_data);
                end else begin
                    eng_exp = exp_tx.pop_front();
                    if (xfer_tx_data !== eng_exp) begin
                        errors++;
                        $display("FAIL tx_byte got %h want %h", xfer_tx_data, eng_exp);
                    end
                end
                xfer_rx_data = (bi >= HDR) ? 8'(8'hA0 + (bi - HDR)) : 8'hFF;
                xfer_done = 1'b1;
                bi++;
                wcnt = 0;
            end
        end else begin
            wcnt = 0;
        end
    end

    // Output monitor: FIFO write scoreboard and activity counters.
    always @(negedge system_clk) begin
        if (done) done_cnt++;
        if (xfer_req) req_cycles++;
        if (!spi_cs_n) cs_low_cycles++;
        if (busy && spi_cs_n) cs_hi_busy++;
        if (fifo_write_req) begin
            wr_cnt++;
            checks++;
            if (exp_fifo.size() == 0) begin
                errors++;
                $display("FAIL fifo_data unexpected write got %h", fifo_dataIn);
            end else begin
                mon_exp = exp_fifo.pop_front();
                if (fifo_dataIn !== mon_exp || fifo_full !== 1'b0) begin
                    errors++;
                    $display("FAIL fifo_data got %h full=%b want %h full=0", fifo_dataIn, fifo_full, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(negedge system_clk);
        #1;
    endtask

    task automatic start_txn(input logic [23:0] a, input int n);
        tick();
        start = 1'b1;
        start_addr = a;
        byte_len = LEN_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic push_expect(input logic [23:0] a, input int n_tx, input int n_fifo);
        exp_tx.push_back(EXP_CMD);
        for (int i = 0; i < 3; i++) exp_tx.push_back(a[23 - 8*i -: 8]);
`ifdef FAST_READ_EN
        exp_tx.push_back(8'h00);
`endif
        for (int i = 0; i < n_tx; i++) exp_tx.push_back(8'h00);
        for (int i = 0; i < n_fifo; i++) exp_fifo.push_back(8'(8'hA0 + i));
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        timed_out = busy;
    endtask

    task automatic test_reset();
        logic [7:0] got[8];
        logic [7:0] want[8];
        system_reset = 1'b1;
        repeat (2) tick();
        got = '{8'(busy), 8'(done), 8'(spi_cs_n), 8'(xfer_req), xfer_tx_data,
                8'(fifo_write_req), fifo_dataIn, 8'(fifo_enable)};
        want = '{8'h0, 8'h0, 8'h1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL reset_out%0d got %h want %h", i, got[i], want[i]);
            end
        end
        system_reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (spi_cs_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release cs_n=%b busy=%b want 1/0", spi_cs_n, busy);
        end
    endtask

    task automatic test_basic_read();
        int bd = done_cnt, bw = wr_cnt, bh = cs_hi_busy;
        bit to;
        push_expect(24'h012345, 4, 4);
        start_txn(24'h012345, 4);
        checks++;
        if (busy !== 1'b1 || spi_cs_n !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept busy=%b cs_n=%b want 1/0", busy, spi_cs_n);
        end
        wait_idle(1000, to);
        tick();
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout busy still high"); end
        checks++;
        if (done_cnt - bd != 1) begin errors++; $display("FAIL basic_done got %0d pulses want 1", done_cnt - bd); end
        checks++;
        if (wr_cnt - bw != 4) begin errors++; $display("FAIL basic_writes got %0d want 4", wr_cnt - bw); end
        checks++;
        if (cs_hi_busy != bh) begin errors++; $display("FAIL basic_cs_low got %0d cs-high busy cycles want 0", cs_hi_busy - bh); end
        checks++;
        if (exp_tx.size() != 0 || exp_fifo.size() != 0) begin
            errors++;
            $display("FAIL basic_leftover got tx=%0d fifo=%0d want 0/0", exp_tx.size(), exp_fifo.size());
        end
    endtask

    task automatic test_zero_len();
        int bd = done_cnt, br = req_cycles, bc = cs_low_cycles;
        start_txn(24'h00AA55, 0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got done=%b busy=%b want 1/0", done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b want 0", done); end
        repeat (3) tick();
        checks++;
        if (done_cnt - bd != 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", done_cnt - bd); end
        checks++;
        if (cs_low_cycles != bc || req_cycles != br) begin
            errors++;
            $display("FAIL zero_no_bus got cs_low=%0d req=%0d want 0/0", cs_low_cycles - bc, req_cycles - br);
        end
    endtask

    task automatic test_backpressure();
        int bd = done_cnt, bw = wr_cnt, br, cs_bad = 0, k = 0;
        bit to;
        push_expect(24'h0ABCDE, 5, 5);
        start_txn(24'h0ABCDE, 5);
        while (wr_cnt - bw < 2 && k < 1000) begin tick(); k++; end
        checks++;
        if (wr_cnt - bw != 2) begin errors++; $display("FAIL bp_reach got %0d writes want 2", wr_cnt - bw); end
        fifo_full = 1'b1;
        br = req_cycles;
        repeat (20) begin
            tick();
            if (spi_cs_n !== 1'b0) cs_bad++;
        end
        checks++;
        if (req_cycles != br) begin errors++; $display("FAIL bp_no_req got %0d req cycles want 0", req_cycles - br); end
        checks++;
        if (cs_bad != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got cs_high=%0d busy=%b want 0/1", cs_bad, busy);
        end
        fifo_full = 1'b0;
        wait_idle(1000, to);
        tick();
        checks++;
        if (to) begin errors++; $display("FAIL bp_timeout busy still high"); end
        checks++;
        if (wr_cnt - bw != 5 || done_cnt - bd != 1) begin
            errors++;
            $display("FAIL bp_complete got writes=%0d done=%0d want 5/1", wr_cnt - bw, done_cnt - bd);
        end
        checks++;
        if (exp_tx.size() != 0 || exp_fifo.size() != 0) begin
            errors++;
            $display("FAIL bp_leftover got tx=%0d fifo=%0d want 0/0", exp_tx.size(), exp_fifo.size());
        end
    endtask

    task automatic test_abort();
        int bd = done_cnt, bw = wr_cnt, k = 0;
        fixed_lat = 3;
        push_expect(24'h001000, 2, 2);
        start_txn(24'h001000, 8);
        while (!(wr_cnt - bw == 2 && xfer_req) && k < 1000) begin tick(); k++; end
        checks++;
        if (!(wr_cnt - bw == 2 && xfer_req === 1'b1)) begin
            errors++;
            $display("FAIL abort_reach got writes=%0d req=%b want 2/1", wr_cnt - bw, xfer_req);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (spi_cs_n !== 1'b1 || busy !== 1'b0 || xfer_req !== 1'b0 || fifo_write_req !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs got cs_n=%b busy=%b req=%b wr=%b want 1/0/0/0",
                     spi_cs_n, busy, xfer_req, fifo_write_req);
        end
        repeat (4) tick();
        fixed_lat = 0;
        checks++;
        if (done_cnt != bd || wr_cnt - bw != 2) begin
            errors++;
            $display("FAIL abort_effect got done=%0d writes=%0d want 0/2", done_cnt - bd, wr_cnt - bw);
        end
        checks++;
        if (exp_tx.size() != 0 || exp_fifo.size() != 0) begin
            errors++;
            $display("FAIL abort_leftover got tx=%0d fifo=%0d want 0/0", exp_tx.size(), exp_fifo.size());
        end
    endtask

    task automatic test_back_to_back();
        int bd = done_cnt, bw = wr_cnt;
        bit to1, to2;
        push_expect(24'h123456, 2, 2);
        push_expect(24'h00FF01, 3, 3);
        start_txn(24'h123456, 2);
        repeat (3) tick();
        start = 1'b1;
        start_addr = 24'h777777;
        byte_len = LEN_W'(7);
        tick();
        start = 1'b0;
        wait_idle(1000, to1);
        start = 1'b1;
        start_addr = 24'h00FF01;
        byte_len = LEN_W'(3);
        tick();
        start = 1'b0;
        wait_idle(1000, to2);
        tick();
        checks++;
        if (to1 || to2) begin errors++; $display("FAIL b2b_timeout got %b/%b want 0/0", to1, to2); end
        checks++;
        if (done_cnt - bd != 2 || wr_cnt - bw != 5) begin
            errors++;
            $display("FAIL b2b_counts got done=%0d writes=%0d want 2/5", done_cnt - bd, wr_cnt - bw);
        end
        checks++;
        if (exp_tx.size() != 0 || exp_fifo.size() != 0) begin
            errors++;
            $display("FAIL b2b_leftover got tx=%0d fifo=%0d want 0/0", exp_tx.size(), exp_fifo.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got[8];
        logic [7:0] want[8];
        int bd = done_cnt, be = eng_cnt, bw, k = 0;
        bit to;
        push_expect(24'h345678, 3, 3);
        start_txn(24'h345678, 3);
        while (eng_cnt - be < 2 && k < 1000) begin tick(); k++; end
        #1;
        system_reset = 1'b1;
        #1;
        got = '{8'(busy), 8'(done), 8'(spi_cs_n), 8'(xfer_req), xfer_tx_data,
                8'(fifo_write_req), fifo_dataIn, 8'(fifo_enable)};
        want = '{8'h0, 8'h0, 8'h1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h1};
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL midreset_out%0d got %h want %h", i, got[i], want[i]);
            end
        end
        repeat (2) tick();
        system_reset = 1'b0;
        exp_tx.delete();
        exp_fifo.delete();
        checks++;
        if (done_cnt != bd) begin errors++; $display("FAIL midreset_no_done got %0d want 0", done_cnt - bd); end
        bd = done_cnt;
        bw = wr_cnt;
        push_expect(24'hFFFFFF, 3, 3);
        start_txn(24'hFFFFFF, 3);
        wait_idle(1000, to);
        tick();
        checks++;
        if (to || done_cnt - bd != 1 || wr_cnt - bw != 3) begin
            errors++;
            $display("FAIL midreset_rerun got to=%b done=%0d writes=%0d want 0/1/3", to, done_cnt - bd, wr_cnt - bw);
        end
        checks++;
        if (exp_tx.size() != 0 || exp_fifo.size() != 0) begin
            errors++;
            $display("FAIL midreset_leftover got tx=%0d fifo=%0d want 0/0", exp_tx.size(), exp_fifo.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_zero_len();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
